// File: rtl/spine_ingress_arbiter.sv
// Four-way spine ingress merger: per-port FIFOs feeding a single registered output
// through a round-robin arbiter that holds each grant for at most BURST_LEN pops.
module spine_ingress_arbiter #(
  parameter int DWIDTH    = 16,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [DWIDTH-1:0] spine1_in_data,
  input  logic [DWIDTH-1:0] spine2_in_data,
  input  logic [DWIDTH-1:0] spine3_in_data,
  input  logic [DWIDTH-1:0] spine4_in_data,
  input  logic              spine1_in_valid,
  input  logic              spine2_in_valid,
  input  logic              spine3_in_valid,
  input  logic              spine4_in_valid,
  output logic              spine1_in_ready,
  output logic              spine2_in_ready,
  output logic              spine3_in_ready,
  output logic              spine4_in_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [5:0]        out_dest_addr,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        grant,
  output logic [3:0]        fifo_full,
  output logic [3:0]        fifo_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [DWIDTH-1:0] in_data [4];
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic [3:0]        full_w;
  logic [3:0]        empty_w;
  logic              ready_en;

  logic [DWIDTH-1:0] mem  [4][DEPTH];
  logic [AW-1:0]     wptr [4];
  logic [AW-1:0]     rptr [4];
  logic [CW-1:0]     cnt  [4];

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        lock_port;
  logic [BW-1:0]     burst_cnt;
  logic [BW-1:0]     burst_next;

  logic              found;
  logic [1:0]        search_port;
  logic [1:0]        idx;
  logic [1:0]        cur_port;
  logic              cur_avail;
  logic              cur_empties;
  logic              out_load;
  logic              rel;
  logic [DWIDTH-1:0] head;

  assign in_data[0] = spine1_in_data;
  assign in_data[1] = spine2_in_data;
  assign in_data[2] = spine3_in_data;
  assign in_data[3] = spine4_in_data;
  assign in_valid   = {spine4_in_valid, spine3_in_valid, spine2_in_valid, spine1_in_valid};

  assign spine1_in_ready = in_ready[0];
  assign spine2_in_ready = in_ready[1];
  assign spine3_in_ready = in_ready[2];
  assign spine4_in_ready = in_ready[3];

  always_comb begin
    full_w  = '0;
    empty_w = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      full_w[p]  = (cnt[p] == CW'(DEPTH));
      empty_w[p] = (cnt[p] == '0);
    end
  end

  // ready_en keeps every port closed until the first edge after reset release
  assign in_ready   = {4{ready_en}} & ~full_w;
  assign push       = in_valid & in_ready;
  assign fifo_full  = full_w;
  assign fifo_empty = empty_w;

  always_comb begin
    found       = 1'b0;
    search_port = '0;
    idx         = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && !empty_w[idx]) begin
        found       = 1'b1;
        search_port = idx;
      end
    end
  end

  // IDLE may pop in the same cycle it takes the lock, giving two-cycle latency
  assign cur_port    = (state == HOLD) ? lock_port : search_port;
  assign cur_avail   = (state == HOLD) ? !empty_w[lock_port] : found;
  assign out_load    = cur_avail && (!out_valid || out_ready);
  assign pop         = out_load ? (4'b0001 << cur_port) : 4'b0000;
  assign cur_empties = (cnt[cur_port] == CW'(1)) && !push[cur_port];
  assign burst_next  = burst_cnt + 1'b1;
  assign head        = mem[cur_port][rptr[cur_port]];

  always_comb begin
    rel = 1'b0;
    if (state == HOLD) begin
      if (out_load)
        rel = (burst_next >= BW'(BURST_LEN)) || cur_empties;
      else
        rel = (burst_cnt >= BW'(BURST_LEN)) || empty_w[lock_port];
    end
  end

  always_ff @(posedge ACLK) begin
    for (int unsigned p = 0; p < 4; p++)
      if (push[p]) mem[p][wptr[p]] <= in_data[p];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ready_en <= 1'b0;
      for (int unsigned p = 0; p < 4; p++) begin
        wptr[p] <= '0;
        rptr[p] <= '0;
        cnt[p]  <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      for (int unsigned p = 0; p < 4; p++) begin
        if (push[p]) wptr[p] <= wptr[p] + 1'b1;
        if (pop[p])  rptr[p] <= rptr[p] + 1'b1;
        if (push[p] && !pop[p])
          cnt[p] <= cnt[p] + 1'b1;
        else if (!push[p] && pop[p])
          cnt[p] <= cnt[p] - 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= '0;
      lock_port <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= head;
        out_src   <= cur_port;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            state     <= HOLD;
            lock_port <= search_port;
            grant     <= 4'b0001 << search_port;
            burst_cnt <= out_load ? BW'(1) : '0;
          end
        end
        HOLD: begin
          if (rel) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= lock_port + 2'd1;
            burst_cnt <= '0;
          end else if (out_load) begin
            burst_cnt <= burst_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_dest_addr = out_data[DWIDTH-1 -: 6];

endmodule

// File: tb/tb_spine_ingress_arbiter.sv
// Scoreboard bench for spine_ingress_arbiter: a negedge driver feeds per-port send
// queues, a posedge monitor moves accepted flits to expected queues and checks output.
module tb_spine_ingress_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] in_d [4];
  logic [3:0]  in_v;
  logic        r1, r2, r3, r4;
  logic [3:0]  in_r;
  logic [15:0] out_data;
  logic [5:0]  out_dest_addr;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  grant;
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_empty;

  logic [15:0] tx_q  [4][$];
  logic [15:0] exp_q [4][$];
  int          src_log [$];
  int          checks = 0;
  int          errors = 0;
  int          rx_total = 0;

  assign in_r = {r4, r3, r2, r1};

  spine_ingress_arbiter #(.DWIDTH(16), .DEPTH(4), .BURST_LEN(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .spine1_in_data(in_d[0]), .spine2_in_data(in_d[1]),
    .spine3_in_data(in_d[2]), .spine4_in_data(in_d[3]),
    .spine1_in_valid(in_v[0]), .spine2_in_valid(in_v[1]),
    .spine3_in_valid(in_v[2]), .spine4_in_valid(in_v[3]),
    .spine1_in_ready(r1), .spine2_in_ready(r2),
    .spine3_in_ready(r3), .spine4_in_ready(r4),
    .out_data(out_data), .out_dest_addr(out_dest_addr), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    in_v = '0;
    for (int p = 0; p < 4; p++) in_d[p] = '0;
    forever begin
      @(negedge ACLK);
      for (int p = 0; p < 4; p++) begin
        if (tx_q[p].size() > 0) begin
          in_v[p] = 1'b1;
          in_d[p] = tx_q[p][0];
        end else begin
          in_v[p] = 1'b0;
          in_d[p] = '0;
        end
      end
    end
  end

  initial begin
    logic [15:0] e;
    forever begin
      @(posedge ACLK);
      if (ARESETn) begin
        for (int p = 0; p < 4; p++)
          if (in_v[p] && in_r[p] && tx_q[p].size() > 0)
            exp_q[p].push_back(tx_q[p].pop_front());
        if (out_valid && out_ready) begin
          rx_total++;
          src_log.push_back(int'(out_src));
          checks++;
          if (exp_q[out_src].size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit: got %h from port %0d, required no flit", out_data, out_src);
          end else begin
            e = exp_q[out_src].pop_front();
            if (out_data !== e) begin
              errors++;
              $display("FAIL flit_data: got %h from port %0d, required %h", out_data, out_src, e);
            end
          end
          checks++;
          if (out_dest_addr !== out_data[15:10]) begin
            errors++;
            $display("FAIL dest_addr: got %h, required %h", out_dest_addr, out_data[15:10]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  function automatic bit busy();
    busy = out_valid;
    for (int p = 0; p < 4; p++)
      if (tx_q[p].size() > 0 || exp_q[p].size() > 0) busy = 1'b1;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (busy() && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, required empty", name, n);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    out_ready = 1'b0;
    #2;
    checks++; if (in_r !== 4'h0) begin errors++; $display("FAIL rst_ready: got %b required 0000", in_r); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0000", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src: got %0d required 0", out_src); end
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL rst_grant: got %b required 0000", grant); end
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL rst_fifo_empty: got %h required F", fifo_empty); end
    checks++; if (fifo_full !== 4'h0) begin errors++; $display("FAIL rst_fifo_full: got %h required 0", fifo_full); end
    tick(2);
    checks++; if (in_r !== 4'h0) begin errors++; $display("FAIL rst_ready_held: got %b required 0000", in_r); end
    ARESETn = 1'b1;
    #1;
    checks++; if (in_r !== 4'h0) begin errors++; $display("FAIL rst_ready_release: got %b required 0000", in_r); end
    tick(1);
    checks++; if (in_r !== 4'hF) begin errors++; $display("FAIL rst_ready_after: got %b required 1111", in_r); end
  endtask

  task automatic test_back_to_back();
    int start;
    int n = 0;
    out_ready = 1'b1;
    src_log.delete();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 8; i++)
        tx_q[p].push_back(16'(((p + 1) << 12) | (p << 8) | i));
    start = rx_total;
    while (rx_total - start < 32 && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (n > 42) begin errors++; $display("FAIL b2b_cycles: got %0d cycles, required <= 42", n); end
    wait_drain("b2b");
    checks++;
    if (src_log.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d flits, required 32", src_log.size()); end
    for (int i = 0; i < src_log.size() && i < 32; i++) begin
      checks++;
      if (src_log[i] != (i / 4) % 4) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got port %0d, required %0d", i, src_log[i], (i / 4) % 4);
      end
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    tick(2);
    tx_q[2].push_back(16'hA4C3);
    tick(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: out_valid got %b required 0", out_valid); end
    checks++; if (in_r[2] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", in_r[2]); end
    tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", out_valid); end
    checks++; if (out_data !== 16'hA4C3) begin errors++; $display("FAIL single_data: got %h required a4c3", out_data); end
    checks++; if (out_dest_addr !== 6'h29) begin errors++; $display("FAIL single_dest: got %h required 29", out_dest_addr); end
    checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL single_src: got %0d required 2", out_src); end
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b required 0100", grant); end
    checks++; if (in_r[2] !== 1'b1) begin errors++; $display("FAIL single_ready2: got %b required 1", in_r[2]); end
    tick(1);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_rel: got %b required 0000", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done: out_valid got %b required 0", out_valid); end
    wait_drain("single");
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tx_q[1].push_back(16'(16'h2100 + i));
    tick(8);
    checks++; if (in_r[1] !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b required 0", in_r[1]); end
    checks++; if (fifo_full[1] !== 1'b1) begin errors++; $display("FAIL stall_full: got %b required 1", fifo_full[1]); end
    checks++; if (tx_q[1].size() != 1) begin errors++; $display("FAIL stall_accepted: got %0d unsent, required 1", tx_q[1].size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h2100) begin
        errors++;
        $display("FAIL stall_hold: got valid %b data %h, required 1 2100", out_valid, out_data);
      end
      tick(1);
    end
    out_ready = 1'b1;
    wait_drain("stall");
  endtask

  task automatic test_rr();
    int exp_src [4] = '{1, 1, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tx_q[0].push_back(16'(16'h0400 + i));
    wait_drain("rr_solo");
    tick(2);
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL rr_grant_idle: got %b required 0000", grant); end
    src_log.delete();
    for (int i = 0; i < 2; i++) begin
      tx_q[0].push_back(16'(16'h0800 + i));
      tx_q[1].push_back(16'(16'h4800 + i));
    end
    wait_drain("rr_pair");
    checks++;
    if (src_log.size() != 4) begin errors++; $display("FAIL rr_count: got %0d required 4", src_log.size()); end
    for (int i = 0; i < src_log.size() && i < 4; i++) begin
      checks++;
      if (src_log[i] != exp_src[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, src_log[i], exp_src[i]);
      end
    end
  endtask

  task automatic test_push_pop();
    int start;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_q[3].push_back(16'(16'hC300 + i));
    tick(6);
    checks++; if (tx_q[3].size() != 0) begin errors++; $display("FAIL pp_fill: got %0d unsent, required 0", tx_q[3].size()); end
    for (int i = 3; i < 13; i++) tx_q[3].push_back(16'(16'hC300 + i));
    out_ready = 1'b1;
    start = rx_total;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      checks++;
      if (fifo_full[3] !== 1'b0 || fifo_empty[3] !== 1'b0) begin
        errors++;
        $display("FAIL pp_level[%0d]: got full %b empty %b, required 0 0", c, fifo_full[3], fifo_empty[3]);
      end
    end
    checks++;
    if (rx_total - start != 10) begin errors++; $display("FAIL pp_rate: got %0d flits in 10 cycles, required 10", rx_total - start); end
    wait_drain("pp");
  endtask

  task automatic test_reset_mid();
    int start;
    int vcount = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_q[0].push_back(16'(16'h1E00 + i));
    tick(5);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_grant_pre: got %b required 0001", grant); end
    #3;
    ARESETn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL mid_grant: got %b required 0000", grant); end
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL mid_fifo_empty: got %h required F", fifo_empty); end
    checks++; if (in_r !== 4'h0) begin errors++; $display("FAIL mid_ready: got %b required 0000", in_r); end
    for (int p = 0; p < 4; p++) begin
      tx_q[p].delete();
      exp_q[p].delete();
    end
    tick(2);
    ARESETn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (out_valid) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL mid_stale: got %0d valid cycles, required 0", vcount); end
    checks++; if (fifo_empty !== 4'hF) begin errors++; $display("FAIL mid_empty_after: got %h required F", fifo_empty); end
    start = rx_total;
    tx_q[0].push_back(16'h5A5A);
    wait_drain("mid_recover");
    checks++; if (rx_total - start != 1) begin errors++; $display("FAIL mid_recover: got %0d flits, required 1", rx_total - start); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_stall();
    test_rr();
    test_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
